// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and the pipeline stages
// that consume its controls.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TRAP     = 2'd2
  } state_e;

  // Writeback-select encoding for loads, shared with the MEM/WB stage.
  localparam logic [1:0]  LOAD_SEL    = 2'b01;
  // Destination register written into a flushed (bubble) stage.
  localparam logic [4:0]  NOP_RD      = 5'b11111;
  // PC mux target when trap_sel is asserted.
  localparam logic [31:0] TRAP_VECTOR = 32'h0000_0100;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic memwb_bubble;
    logic trap_sel;
  } ctrl_t;

  // Free-running pipeline: everything loads, nothing is squashed.
  function automatic ctrl_t ctrl_run();
    ctrl_t c;
    c = '0;
    c.pc_en    = 1'b1;
    c.ifid_en  = 1'b1;
    c.idex_en  = 1'b1;
    c.exmem_en = 1'b1;
    return c;
  endfunction

  // Data memory not ready: hold PC..EX/MEM, let MEM/WB drain a bubble.
  function automatic ctrl_t ctrl_freeze();
    ctrl_t c;
    c = '0;
    c.memwb_bubble = 1'b1;
    return c;
  endfunction

  // Redirect in EX: the two younger instructions are wrong-path.
  function automatic ctrl_t ctrl_branch();
    ctrl_t c;
    c = ctrl_run();
    c.ifid_flush = 1'b1;
    c.idex_flush = 1'b1;
    return c;
  endfunction

  // Load in EX feeds ID: hold PC and IF/ID, insert one bubble into ID/EX.
  function automatic ctrl_t ctrl_load_use();
    ctrl_t c;
    c = ctrl_run();
    c.pc_en      = 1'b0;
    c.ifid_en    = 1'b0;
    c.idex_flush = 1'b1;
    return c;
  endfunction

  // Memory fault: squash every in-flight instruction and vector to the trap.
  function automatic ctrl_t ctrl_trap();
    ctrl_t c;
    c = ctrl_run();
    c.ifid_flush   = 1'b1;
    c.idex_flush   = 1'b1;
    c.exmem_flush  = 1'b1;
    c.memwb_bubble = 1'b1;
    c.trap_sel     = 1'b1;
    return c;
  endfunction

  // Held in reset: nothing loads, every stage is forced to a bubble.
  function automatic ctrl_t ctrl_reset();
    ctrl_t c;
    c = '0;
    c.ifid_flush   = 1'b1;
    c.idex_flush   = 1'b1;
    c.exmem_flush  = 1'b1;
    c.memwb_bubble = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline status in / pipeline control out bundle for the hazard controller.
// master: the controller. slave: the pipeline datapath.
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_RegW;
  logic [1:0]       ex_MemReg;
  logic             ex_branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_en;
  logic             ifid_en;
  logic             idex_en;
  logic             exmem_en;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             memwb_bubble;
  logic             trap_sel;
  logic             mem_fault;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_RegW, ex_MemReg,
           ex_branch_taken, mem_req, mem_ready,
    output pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
           exmem_flush, memwb_bubble, trap_sel, mem_fault, stall_cycles
  );

  modport slave (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_RegW, ex_MemReg,
           ex_branch_taken, mem_req, mem_ready,
    input  pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush,
           exmem_flush, memwb_bubble, trap_sel, mem_fault, stall_cycles
  );
endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Load-use hazard detect: a load in EX whose destination is read by ID.
module load_use_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1_i,
  input  logic [4:0] id_rs2_i,
  input  logic       id_use_rs1_i,
  input  logic       id_use_rs2_i,
  input  logic [4:0] ex_rd_i,
  input  logic       ex_RegW_i,
  input  logic [1:0] ex_MemReg_i,
  output logic       hazard_o
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never blocks anything.
  always_comb begin
    ex_is_load = ex_RegW_i && (ex_MemReg_i == LOAD_SEL) && (ex_rd_i != 5'd0);
    rs1_hit    = id_use_rs1_i && (id_rs1_i == ex_rd_i);
    rs2_hit    = id_use_rs2_i && (id_rs2_i == ex_rd_i);
    hazard_o   = ex_is_load && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline: load-use,
// taken-branch and data-memory wait hazards, bounded memory wait with trap,
// and a stall-cycle performance counter.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; hazards resolved by priority each cycle
// MEM_WAIT | data access outstanding; pipeline frozen until mem_ready
// TRAP     | one cycle: squash all stages, PC takes the trap vector
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 32
) (
  input logic               clk,
  input logic               rst_n,
  pipe_hazard_ctrl_if.master bus
);

  localparam logic [8:0] MAX_WAIT_C = 9'(MAX_WAIT);

  state_e           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d;
  logic             mem_fault_q;
  logic [CNT_W-1:0] stall_q;

  logic             load_use;
  logic             freeze;
  logic [8:0]       wait_next;
  ctrl_t            ctrl;

  load_use_detect u_load_use (
    .id_rs1_i     (bus.id_rs1),
    .id_rs2_i     (bus.id_rs2),
    .id_use_rs1_i (bus.id_use_rs1),
    .id_use_rs2_i (bus.id_use_rs2),
    .ex_rd_i      (bus.ex_rd),
    .ex_RegW_i    (bus.ex_RegW),
    .ex_MemReg_i  (bus.ex_MemReg),
    .hazard_o     (load_use)
  );

  // Next state, wait counter and zero-latency pipeline controls.
  always_comb begin
    state_d    = RUN;
    wait_cnt_d = '0;
    ctrl       = ctrl_run();
    // Once waiting, the stalled request stays frozen in MEM, so only
    // mem_ready matters there.
    freeze     = !bus.mem_ready && ((state_q == MEM_WAIT) || bus.mem_req);
    // wait_cnt_q counts frozen cycles already completed, so wait_next is the
    // count including the current one; the timeout fires on the MAX_WAIT-th.
    wait_next  = {1'b0, wait_cnt_q} + 9'd1;

    if (state_q == TRAP) begin
      ctrl = ctrl_trap();
    end else if (freeze) begin
      ctrl       = ctrl_freeze();
      wait_cnt_d = wait_next[7:0];
      state_d    = (wait_next == MAX_WAIT_C) ? TRAP : MEM_WAIT;
    end else if (bus.ex_branch_taken) begin
      ctrl = ctrl_branch();
    end else if (load_use) begin
      ctrl = ctrl_load_use();
    end

    if (!rst_n) begin
      ctrl = ctrl_reset();
    end
  end

  // FSM state, wait counter and the registered fault pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_fault_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_fault_q <= (state_d == TRAP);
    end
  end

  // Stall performance counter: one tick per cycle the PC is held; wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (!ctrl.pc_en) begin
      stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign bus.pc_en        = ctrl.pc_en;
  assign bus.ifid_en      = ctrl.ifid_en;
  assign bus.idex_en      = ctrl.idex_en;
  assign bus.exmem_en     = ctrl.exmem_en;
  assign bus.ifid_flush   = ctrl.ifid_flush;
  assign bus.idex_flush   = ctrl.idex_flush;
  assign bus.exmem_flush  = ctrl.exmem_flush;
  assign bus.memwb_bubble = ctrl.memwb_bubble;
  assign bus.trap_sel     = ctrl.trap_sel;
  assign bus.mem_fault    = mem_fault_q;
  assign bus.stall_cycles = stall_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the 5-stage RV32 pipeline. Drives the enable, flush and bubble controls of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Resolves three hazards: load-use, taken branch/jump, and data-memory wait states. A bounded-wait FSM raises a memory-fault trap, and a stall-cycle performance counter is kept.

## Interface
Parameters:
- MAX_WAIT, 15: maximum consecutive not-ready cycles on a data-memory access before a fault; range 1..255.
- CNT_W, 32: width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock; one clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_RegW  in  1  the EX instruction writes the register file.
- ex_MemReg  in  2  writeback select of the EX instruction; LOAD_SEL means a load.
- ex_branch_taken  in  1  the EX instruction redirects the PC (taken branch, JAL, JALR).
- mem_req  in  1  the MEM instruction accesses data memory this cycle.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en  out  1 each  register load enables.
- ifid_flush, idex_flush, exmem_flush  out  1 each  load a NOP/bubble (RegW=0, rd=5'b11111).
- memwb_bubble  out  1  MEM/WB captures RegW=0 this cycle.
- trap_sel  out  1  PC mux selects the trap vector.
- mem_fault  out  1  registered one-cycle fault pulse.
- stall_cycles  out  CNT_W  count of cycles with pc_en=0.

## Operation
- FSM states: RUN, MEM_WAIT, TRAP. Control outputs are combinational from the state and the inputs. The state, wait_cnt (8 bits), mem_fault and stall_cycles are registered.
- Priority in RUN: memory wait > taken branch > load-use > normal.
- Normal operation: all enables are 1, all flushes, memwb_bubble and trap_sel are 0.
- Memory wait (mem_req=1, mem_ready=0):
  - pc_en, ifid_en, idex_en and exmem_en are 0; memwb_bubble is 1; no flushes.
  - Next state is MEM_WAIT with wait_cnt set to 1.
- Taken branch (ex_branch_taken=1): ifid_flush and idex_flush are 1, all enables are 1. This gives a 2-bubble penalty.
- Load-use:
  - Condition: ex_RegW=1, ex_MemReg=LOAD_SEL, ex_rd!=0, and ex_rd matches an id_rsN whose id_use_rsN=1.
  - Action: pc_en=0, ifid_en=0, idex_flush=1, for exactly 1 bubble.
  - A register index of 0 never creates a hazard.
- MEM_WAIT:
  - While mem_ready=0, outputs are the same as for a memory wait and wait_cnt increments.
  - When mem_ready=1: freeze released that same cycle, next state RUN. A branch or load-use condition held frozen in EX/ID is then evaluated in that cycle by the normal priority rules.
  - When mem_ready=0 and wait_cnt==MAX_WAIT: next state TRAP.
- TRAP (exactly one cycle):
  - Outputs: trap_sel=1, pc_en=1, all flushes 1, memwb_bubble=1.
  - mem_fault is 1 during this cycle.
  - Next state RUN; wait_cnt is cleared to 0.
- stall_cycles increments on every cycle with rst_n high and pc_en=0, and wraps modulo 2^CNT_W.

## Timing
- Reset (rst_n low): state=RUN, wait_cnt=0, mem_fault=0, stall_cycles=0.
- While rst_n is low, combinational outputs are forced as follows: all enables 0, all flushes 1, memwb_bubble 1, trap_sel 0.
- Reset asserted mid-MEM_WAIT or mid-TRAP aborts immediately: no fault pulse, and the counters are cleared.
- A hazard takes effect in the cycle it is detected (zero latency); the register update lands on the next clock edge.
- mem_fault rises on the edge that enters TRAP and falls one edge later.
- MEM_WAIT length: a timeout at MAX_WAIT=15 gives exactly 15 frozen cycles, then 1 TRAP cycle.
- mem_ready=1 on the first cycle of a request means no wait, no state change, no stall count.
- A load-use stall and a taken branch in the same cycle resolve to the branch. The load in EX proceeds and the dependent instruction is flushed anyway.

## Structure
- Shared package pipe_ctrl_pkg:
  - state enum {RUN, MEM_WAIT, TRAP};
  - LOAD_SEL = 2'b01 (writeback-select encoding shared with the MEM/WB stage);
  - NOP_RD = 5'b11111;
  - TRAP_VECTOR constant used by the PC mux.
- One sub-module, load_use_detect: purely combinational register-compare unit producing a single hazard bit. The FSM, the priority logic and the counters stay in the top module.

## Test plan
- Load-use: ex_MemReg=LOAD_SEL, ex_RegW=1, ex_rd=5, id_rs2=5, id_use_rs2=1 → one cycle of pc_en=0, idex_flush=1; stall_cycles=1. Repeat with ex_rd=0 → no stall.
- Branch plus load-use: ex_branch_taken=1 in the same cycle as a load-use hazard → ifid_flush=idex_flush=1, pc_en=1; stall_cycles unchanged.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles, then high → pc_en=0 and memwb_bubble=1 for 3 cycles, release on cycle 4; stall_cycles=3; no mem_fault.
- Timeout: MAX_WAIT=4, mem_ready held low → 4 frozen cycles, then 1 cycle with trap_sel=1, all flushes 1 and mem_fault=1, then RUN.
- Reset mid-wait: rst_n dropped on wait cycle 2 → state RUN, mem_fault=0, stall_cycles=0; forced reset outputs while rst_n is low.
- Counter wrap: CNT_W=4 with 17 stall cycles → stall_cycles=1.
